uart_byte_rx: RTL and testbench

Receive half of the Modbus RTU slave UART: deserialises 8N1 frames from the rs232_rx pin into bytes for the RTU frame assembler.
- Oversamples with the system clock; each bit is sampled at its centre.
- Pulses rx_done once per good byte.
- Flags stop-bit violations as framing errors.
- Mirrors the transmit side: same parameters, bit order LSB first, no parity.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sync.sv | 35 +++
 rtl/uart_byte_rx.sv | 117 +++++++++++
 tb/tb_uart_byte_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared UART types, framing constants and baud divisor.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_fsm_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // Clocks per bit; the transmitter uses the same rounding so both ends agree.
  function automatic int unsigned bps_calc(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_sync : 3-flop line synchroniser (idle-high) with fall detect.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  output logic rx_sync,
  output logic fall
);

  logic r_rx_s1;
  logic r_rx_s2;
  logic r_rx_s3;

  // Reset to the idle level so releasing reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= rx_in;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  assign rx_sync = r_rx_s2;
  assign fall    = r_rx_s3 & ~r_rx_s2;

endmodule
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_byte_rx : 8N1 UART byte receiver, centre-sampled, framing check.|
// | Option macro: UART_RX_MAJORITY_EN (2-of-3 vote around each centre).  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_state,
  output logic       frame_err
);

  localparam int unsigned c_bps     = bps_calc(CLK_FREQ, BAUD_RATE);
  localparam logic [15:0] c_bit_tgt = 16'(c_bps - 1);
`ifdef UART_RX_MAJORITY_EN
  // Start check runs one clock longer so later bit decisions land on centre+1.
  localparam logic [15:0] c_start_tgt = 16'(c_bps / 2);
`else
  localparam logic [15:0] c_start_tgt = 16'(c_bps / 2 - 1);
`endif

  rx_fsm_t     r_state;
  rx_fsm_t     w_state_nx;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        w_rx;
  logic        w_fall;
  logic        w_active;
  logic        w_tick;
  logic        w_bit;
  logic        w_done_set;
  logic        w_ferr_set;
  logic        w_shift_en;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_in   (rs232_rx),
    .rx_sync (w_rx),
    .fall    (w_fall)
  );

  assign w_active = (r_state == START) || (r_state == DATA) || (r_state == STOP);
  assign w_tick   = w_active && (r_cnt == ((r_state == START) ? c_start_tgt : c_bit_tgt));

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hist <= 2'b11;
    else        r_hist <= {r_hist[0], w_rx};
  end

  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx) | (r_hist[0] & w_rx);
`else
  assign w_bit = w_rx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (w_fall) w_state_nx = START;
      START:   if (w_tick) w_state_nx = (w_bit == START_BIT) ? DATA : IDLE;
      DATA:    if (w_tick && (r_idx == 3'(DATA_BITS - 1))) w_state_nx = STOP;
      STOP:    if (w_tick) w_state_nx = (w_bit == STOP_BIT) ? IDLE : BREAK;
      BREAK:   if (w_rx == STOP_BIT) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    rx_state   = (r_state != IDLE);
    w_shift_en = (r_state == DATA) && w_tick;
    w_done_set = (r_state == STOP) && w_tick && (w_bit == STOP_BIT);
    w_ferr_set = (r_state == STOP) && w_tick && (w_bit != STOP_BIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 16'd0;
      r_idx     <= 3'd0;
      r_shift   <= 8'h00;
      rx_data   <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (!w_active || w_tick || (w_state_nx != r_state)) r_cnt <= 16'd0;
      else                                                 r_cnt <= r_cnt + 16'd1;

      if (r_state != DATA) r_idx <= 3'd0;
      else if (w_tick)     r_idx <= r_idx + 3'd1;

      if (w_shift_en) r_shift[r_idx] <= w_bit;
      if (w_done_set) rx_data <= r_shift;

      rx_done   <= w_done_set;
      frame_err <= w_ferr_set;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_byte_rx : directed + random frames against a byte scoreboard.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_byte_rx;

  localparam int CLK_FREQ  = 50000000;
  localparam int BAUD_RATE = 115200;
  localparam int BPS       = CLK_FREQ / BAUD_RATE;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT_SLIP = 1;
`else
  localparam int LAT_SLIP = 0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       line  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_state;
  logic       frame_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int last_fall = 0;
  int d0, f0, hi, per, gap;
  logic [7:0] last_good = 8'h00;
  logic [7:0] rb;
  logic [7:0] pat;
  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs232_rx  (line),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_state  (rx_state),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_done) begin
        got_q.push_back(rx_data);
        got_cyc.push_back(cyc);
        done_cnt++;
      end
      if (frame_err) ferr_cnt++;
      if (rx_done || frame_err) begin
        n_assert++;
        assert (!(rx_done && frame_err)) else begin
          n_fail++;
          $error("FAIL done_ferr_overlap: observed done=%0b ferr=%0b expected never both", rx_done, frame_err);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi_lim);
    n_assert++;
    assert (obs >= lo && obs <= hi_lim) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected in [%0d,%0d]", tag, obs, lo, hi_lim);
    end
  endtask

  task automatic drive_bits(input logic v, input int n);
    line = v;
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a frame with a high stop bit must yield exactly its byte.
  task automatic send_frame(input logic [7:0] b, input int p, input logic stop_v, input int stop_len);
    last_fall = cyc;
    drive_bits(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bits(b[i], p);
    drive_bits(stop_v, stop_len);
    if (stop_v) begin
      exp_q.push_back(b);
      last_good = b;
    end
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_done", rx_done, 1'b0);
    chk("rst_rx_state", rx_state, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    rst_n = 1'b1;
    drive_bits(1'b1, 100);
    chk("idle_rx_state", rx_state, 1'b0);

    send_frame(8'hA5, BPS, 1'b1, BPS);
    drive_bits(1'b1, 200);
    chk("a5_pulses", got_q.size(), 1);
    if (got_cyc.size() > 0)
      chk_range("a5_latency", got_cyc[0] - last_fall, 4120, 4126 + LAT_SLIP);
    chk("a5_rx_data", rx_data, 8'hA5);
    check_rx("a5");
    chk("a5_ferr", ferr_cnt, 0);

    send_frame(8'h00, BPS, 1'b1, BPS);
    send_frame(8'hFF, BPS, 1'b1, BPS);
    send_frame(8'h55, BPS, 1'b1, BPS);
    drive_bits(1'b1, 200);
    check_rx("b2b");
    chk("b2b_ferr", ferr_cnt, 0);

    for (int k = 0; k < 3; k++) begin
      rb  = 8'($urandom);
      per = (k == 0) ? 421 : ((k == 1) ? BPS : 447);
      gap = $urandom_range(0, 40);
      drive_bits(1'b1, gap);
      send_frame(rb, per, 1'b1, per);
    end
    drive_bits(1'b1, 300);
    check_rx("rand");

    send_frame(8'h81, 421, 1'b1, 421);
    drive_bits(1'b1, 200);
    chk("skew_fast_data", rx_data, 8'h81);
    send_frame(8'h81, 447, 1'b1, 447);
    drive_bits(1'b1, 200);
    check_rx("skew");
    chk("skew_ferr", ferr_cnt, 0);

    d0 = done_cnt;
    f0 = ferr_cnt;
    hi = 0;
    line = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (i == 100) line = 1'b1;
      @(negedge clk);
      if (rx_state) hi++;
    end
    chk_range("glitch_state_len", hi, BPS / 2 - 10, 220);
    chk("glitch_state_end", rx_state, 1'b0);
    chk("glitch_done", done_cnt - d0, 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);

    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, BPS, 1'b0, 2000);
    line = 1'b1;
    repeat (2) @(negedge clk);
    chk("brk_state_hold", rx_state, 1'b1);
    @(negedge clk);
    chk("brk_state_fall", rx_state, 1'b0);
    drive_bits(1'b1, 200);
    chk("brk_ferr_once", ferr_cnt - f0, 1);
    chk("brk_no_done", done_cnt - d0, 0);
    chk("brk_rx_data", rx_data, last_good);
    check_rx("brk");

    d0 = done_cnt;
    pat = 8'h96;
    last_fall = cyc;
    drive_bits(1'b0, BPS);
    for (int i = 0; i < 4; i++) drive_bits(pat[i], BPS);
    drive_bits(pat[4], BPS / 2);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_state", rx_state, 1'b0);
    chk("rst_mid_data", rx_data, 8'h00);
    last_good = 8'h00;
    line = 1'b1;
    rst_n = 1'b1;
    drive_bits(1'b1, BPS * 8);
    chk("rst_abort_no_done", done_cnt - d0, 0);
    send_frame(8'h69, BPS, 1'b1, BPS);
    drive_bits(1'b1, 200);
    chk("rst_recover_data", rx_data, 8'h69);
    check_rx("rst_recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
